// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : RISC-V instruction-fetch stage. Owns PC_F, issues one      |
// |               outstanding request at a time to a variable-latency        |
// |               instruction memory and drives the F-D pipeline register.   |
// |               Optional macro FETCH_PERF_EN adds fetched/dropped counters.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_x,
    input  logic [31:0] pc_target_x,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_hold;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    logic [1:0]  w_next_state;
    logic [31:0] w_pc_f_next;
    logic [31:0] w_pc_plus4;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic        w_capture;

    assign w_pc_plus4 = r_pc_f + 32'd4;

    always_comb begin
        w_next_state    = r_state;
        w_pc_f_next     = r_pc_f;
        w_req           = 1'b0;
        w_addr          = r_pc_f;
        w_deliver       = 1'b0;
        w_deliver_instr = imem_rdata;
        w_capture       = 1'b0;
        if (pc_src_x) begin
            // Redirect wins everywhere; an in-flight response must still drain.
            w_pc_f_next = pc_target_x;
            case (r_state)
                S_WAIT, S_DROP: w_next_state = imem_rvalid ? S_IDLE : S_DROP;
                default:        w_next_state = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stall_f) begin
                        w_req        = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall_d) begin
                            w_deliver   = 1'b1;
                            w_pc_f_next = w_pc_plus4;
                            if (!stall_f) begin
                                w_req  = 1'b1;
                                w_addr = w_pc_plus4;
                            end else begin
                                w_next_state = S_IDLE;
                            end
                        end else begin
                            w_capture    = 1'b1;
                            w_next_state = S_HELD;
                        end
                    end
                end
                S_HELD: begin
                    if (!stall_d) begin
                        w_deliver       = 1'b1;
                        w_deliver_instr = r_hold;
                        w_pc_f_next     = w_pc_plus4;
                        w_next_state    = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc_f  <= RESET_PC;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_pc_f  <= w_pc_f_next;
            if (w_capture) begin
                r_hold <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (flush_d) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (stall_d) begin
            r_instr_d <= r_instr_d;
        end else if (w_deliver) begin
            r_instr_d    <= w_deliver_instr;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end else begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic        w_drop;

    // A response is discarded if it lands in DROP or coincides with a redirect.
    assign w_drop = imem_rvalid && ((r_state == S_DROP) || ((r_state == S_WAIT) && pc_src_x));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_dropped <= 32'd0;
        end else begin
            if (w_deliver && !flush_d) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`else
    assign perf_fetched = 32'd0;
    assign perf_dropped = 32'd0;
`endif

    assign imem_req   = w_req && !reset;
    assign imem_addr  = w_addr;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC-V core.
- Owns PC_F and issues requests to a variable-latency instruction memory (one outstanding request at a time).
- Handles stall_f/stall_d/flush_d from the hazard unit and redirects from pc_src_x/pc_target_x.
- Drives the F-D register: instr_d feeds the controller's op/funct3/funct7_b5 and rs1_d/rs2_d decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into instr_d on flush/bubble.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall_f  in  1  hazard unit: do not issue a new fetch
- stall_d  in  1  hazard unit: hold F-D register
- flush_d  in  1  hazard unit: load bubble into F-D
- pc_src_x  in  1  redirect taken (branch/jump in X)
- pc_target_x  in  32  redirect target
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  32  request word address (byte address, [1:0]=0)
- imem_rvalid  in  1  response valid, ≥1 cycle after imem_req
- imem_rdata  in  32  response instruction
- instr_d  out  32  F-D instruction
- pc_d  out  32  F-D PC
- pc_plus4_d  out  32  F-D PC+4
- valid_d  out  1  F-D holds a real instruction
- perf_fetched  out  32  instructions delivered to F-D (optional feature)
- perf_dropped  out  32  responses discarded by redirect (optional feature)

Behaviour:
- Reset: pc_f=RESET_PC, state=IDLE, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, hold register cleared, perf counters=0, imem_req=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - HELD: response captured while stall_d was high.
  - DROP: outstanding response must be discarded.
- Redirect (pc_src_x=1) has top priority in every state:
  - pc_f<=pc_target_x; no imem_req that cycle.
  - IDLE→IDLE, HELD→IDLE (hold register discarded), WAIT→DROP (or →IDLE if imem_rvalid the same cycle, response discarded), DROP→DROP (or →IDLE if imem_rvalid).
- IDLE, no redirect: imem_req=!stall_f, imem_addr=pc_f. On a request go to WAIT.
- WAIT, imem_rvalid=1, no redirect:
  - If !stall_d: instr delivered to F-D, pc_f<=pc_f+4. If !stall_f, issue the next request the same cycle (imem_addr=pc_f+4) and stay WAIT; otherwise go to IDLE.
  - If stall_d: capture imem_rdata into the hold register, go to HELD.
- HELD, !stall_d: deliver the hold register to F-D, pc_f<=pc_f+4, go to IDLE. No request is issued this cycle.
- DROP, imem_rvalid: discard the response, perf_dropped+1, go to IDLE.
- Delivery loads instr_d=instruction, pc_d=pc_f, pc_plus4_d=pc_f+4 (mod 2^32, wraps), valid_d=1.
- F-D update priority: reset > flush_d (bubble) > stall_d (hold) > delivery > bubble.
  - Bubble loads instr_d=NOP_INSTR and valid_d=0; pc_d and pc_plus4_d hold.
  - Any cycle with no delivery and !stall_d is a bubble.
- flush_d on a delivery cycle: the instruction is lost. flush_d is only asserted together with pc_src_x, which already re-targets pc_f.
- imem_rvalid in IDLE or HELD is a protocol error and is ignored.
- Throughput: 1 instruction/cycle with 1-cycle memory and no stalls. First delivery at the edge ending the first imem_rvalid cycle.
- Reset mid-request: the FSM returns to IDLE. The memory must not return a response after reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every delivery to F-D.
  - perf_dropped increments on every discarded response (redirect in WAIT/DROP coincident with or before rvalid).
  - Both counters are 32-bit and wrap.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Reset, 1-cycle memory, no stalls → imem_addr 0,4,8,… on consecutive cycles. Deliveries start on the second cycle after reset release: pc_d=0 with valid_d=1, then pc_d=4, 8, …; perf_fetched=N after N deliveries.
- stall_d high for 3 cycles while the response for pc 0x10 arrives → FSM in HELD; instr_d/pc_d unchanged during the stall. One cycle after stall_d drops, pc_d=0x10 with instr_d=captured word; next imem_addr=0x14.
- Redirect pc_src_x=1, pc_target_x=0x200 while in WAIT with a 3-cycle memory → the late response is discarded, perf_dropped=1. Next imem_addr=0x200 and the next valid pc_d=0x200.
- pc_src_x and imem_rvalid in the same cycle → response discarded, no delivery. flush_d makes instr_d=0x00000013 and valid_d=0; next request to target.
- stall_f high for 4 cycles in IDLE → no imem_req; valid_d=0 bubbles each cycle; fetch resumes at the unchanged pc_f.
- pc_f=0xFFFFFFFC delivered → pc_plus4_d=0x00000000; reset asserted mid-WAIT → all outputs at reset values next cycle, imem_addr=RESET_PC.
